// File: rtl/egress_port_buffer_pkg.sv
// Shared types for the destination-tagged and plain 16-bit AXI-stream links
// feeding and leaving the egress port buffer.
package egress_port_buffer_pkg;

   localparam int unsigned DEST_W_DEFAULT = 2;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned WORD_W         = DATA_W + 1;

   typedef struct packed {
      logic              tvalid;
      logic [DATA_W-1:0] tdata;
      logic              tlast;
   } axis_source_t;

   typedef struct packed {
      logic tready;
   } axis_sink_t;

   typedef struct packed {
      logic                      tvalid;
      logic [DATA_W-1:0]         tdata;
      logic                      tlast;
      logic [DEST_W_DEFAULT-1:0] tdest;
   } axis_d_source_t;

   typedef struct packed {
      logic tready;
   } axis_d_sink_t;

   typedef enum logic [1:0] {
      StIdle,
      StStore,
      StDiscard
   } wr_state_e;

endpackage

// File: rtl/egress_frame_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// registered read data that holds its value while rd_en is low.
module egress_frame_ram #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned WIDTH  = 17,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/egress_port_buffer.sv
// Store-and-forward egress buffer: keeps frames tagged for PORT_ID, commits
// them on tlast, drops overflowing frames whole and drains onto AXI-stream.
module egress_port_buffer
   import egress_port_buffer_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned PORT_ID = 0,
   parameter int unsigned DEST_W  = DEST_W_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  axis_d_source_t ingress_source,
   output axis_d_sink_t   ingress_sink,
   output axis_source_t   egress_source,
   input  axis_sink_t     egress_sink,
   output logic [31:0]    drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t commit_ptr_q, commit_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t rd_addr_q, rd_addr_d;

   wr_state_e state_q, state_d;

   logic              tready_q;
   logic [31:0]       drop_q, drop_d;
   logic              ram_valid_q, ram_valid_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_word_q, out_word_d;
   logic [WORD_W-1:0] rd_data;

   logic accept, full, dest_ok, last;
   logic wr_en, rd_en, out_load, drop_frame;

   assign accept  = ingress_source.tvalid & tready_q;
   assign last    = ingress_source.tlast;
   assign full    = (wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);
   assign dest_ok = ingress_source.tdest[DEST_W-1:0] == PORT_ID[DEST_W-1:0];

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      wr_en        = 1'b0;
      drop_frame   = 1'b0;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (dest_ok && en) begin
                  if (full) begin
                     drop_frame = 1'b1;
                     if (!last) state_d = StDiscard;
                  end else begin
                     wr_en    = 1'b1;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     if (last) commit_ptr_d = wr_ptr_q + 1'b1;
                     else      state_d      = StStore;
                  end
               end else if (!last) begin
                  state_d = StDiscard;
               end
            end
            StStore: begin
               if (full) begin
                  // Roll back the partial frame; the rest of it is swallowed.
                  wr_ptr_d   = commit_ptr_q;
                  drop_frame = 1'b1;
                  state_d    = last ? StIdle : StDiscard;
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (last) begin
                     commit_ptr_d = wr_ptr_q + 1'b1;
                     state_d      = StIdle;
                  end
               end
            end
            StDiscard: begin
               if (last) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
      drop_d = (drop_frame && (drop_q != '1)) ? drop_q + 32'd1 : drop_q;
   end

   // Read pipeline: RAM read stage then output register. rd_addr leads; rd_ptr
   // frees a slot only once its word reaches the output register.
   always_comb begin
      out_load    = ram_valid_q && (!out_valid_q || egress_sink.tready);
      rd_en       = (rd_addr_q != commit_ptr_q) && (!ram_valid_q || out_load);
      rd_addr_d   = rd_en ? rd_addr_q + 1'b1 : rd_addr_q;
      rd_ptr_d    = out_load ? rd_ptr_q + 1'b1 : rd_ptr_q;
      ram_valid_d = rd_en || (ram_valid_q && !out_load);
      out_valid_d = out_load || (out_valid_q && !egress_sink.tready);
      out_word_d  = out_load ? rd_data : out_word_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         rd_addr_q    <= '0;
         tready_q     <= 1'b0;
         drop_q       <= '0;
         ram_valid_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_word_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_addr_q    <= rd_addr_d;
         tready_q     <= 1'b1;
         drop_q       <= drop_d;
         ram_valid_q  <= ram_valid_d;
         out_valid_q  <= out_valid_d;
         out_word_q   <= out_word_d;
      end
   end

   egress_frame_ram #(
      .DEPTH  (DEPTH),
      .WIDTH  (WORD_W),
      .ADDR_W (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data ({ingress_source.tlast, ingress_source.tdata}),
      .rd_en   (rd_en),
      .rd_addr (rd_addr_q[AW-1:0]),
      .rd_data (rd_data)
   );

   assign ingress_sink.tready = tready_q;
   assign egress_source.tvalid = out_valid_q;
   assign egress_source.tdata  = out_word_q[DATA_W-1:0];
   assign egress_source.tlast  = out_word_q[WORD_W-1];
   assign drop_count = drop_q;

endmodule
